// File: rtl/multi_channel_uart_framer.sv
// N-channel sensor framer: latches samples, arbitrates round-robin and streams
// ID / data / checksum / terminator bytes to a byte-wide UART via start/busy.
`timescale 1ns/1ps
module multi_channel_uart_framer #(
  parameter int         NUM_CH      = 4,
  parameter int         DATA_W      = 16,
  parameter logic [7:0] ID_BASE     = 8'hA0,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter logic [7:0] TERMINATOR  = 8'h0A,
  parameter int         GAP_CYCLES  = 2000,
  parameter int         ACK_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     clear_flags,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic                     frame_active,
  output logic [NUM_CH-1:0]        overrun,
  output logic                     tx_error
);
  // state     | meaning
  // IDLE      | no frame in flight, waiting for a pending channel
  // TRIGGER   | tx_start high, waiting for tx_busy or ack timeout
  // WAIT_DONE | UART busy with current byte
  // GAP       | idle spacing after a byte
  localparam int NB  = DATA_W / 8;
  localparam int LEN = 2 + NB + (CHECKSUM_EN ? 1 : 0);
  localparam int PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW  = $clog2(LEN);
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam int AW  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, TRIGGER, WAIT_DONE, GAP} state_t;
  state_t state, state_nx;

  logic [DATA_W-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] pending, ovr_set;
  logic [PW-1:0]     ptr, grant_idx;
  logic              grant_any, grant, timeout, last, abort;
  logic [DATA_W-1:0] frm_data;
  logic [7:0]        frm_id, grant_id, csum, next_byte;
  logic [BW-1:0]     byte_idx, nxt_idx;
  logic [GW-1:0]     gap_cnt;
  logic [AW-1:0]     ack_cnt;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] base, input int off);
    int c;
    c = int'(base) + off;
    if (c >= NUM_CH) c = c - NUM_CH;
    return PW'(c);
  endfunction

  // Scan offsets from the far end so the closest pending channel to ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[rr_next(ptr, i)]) begin
        grant_any = 1'b1;
        grant_idx = rr_next(ptr, i);
      end
    end
  end

  assign grant    = (state == IDLE) && grant_any;
  assign grant_id = ID_BASE + 8'(grant_idx);
  assign timeout  = (state == TRIGGER) && !tx_busy && (ack_cnt == '0);
  assign last     = abort || (byte_idx == BW'(LEN - 1));
  assign nxt_idx  = byte_idx + BW'(1);

  always_comb begin
    ovr_set = '0;
    for (int k = 0; k < NUM_CH; k++)
      ovr_set[k] = ch_valid[k] && pending[k] && !(grant && int'(grant_idx) == k);
  end

  always_comb begin
    csum = frm_id;
    for (int b = 0; b < NB; b++) csum = csum ^ frm_data[b*8 +: 8];
    next_byte = TERMINATOR;
    for (int b = 0; b < NB; b++)
      if (int'(nxt_idx) == b + 1) next_byte = frm_data[(NB-1-b)*8 +: 8];
    if (CHECKSUM_EN && int'(nxt_idx) == NB + 1) next_byte = csum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (grant_any) state_nx = TRIGGER;
      TRIGGER:   if (tx_busy) state_nx = WAIT_DONE;
                 else if (ack_cnt == '0) state_nx = GAP;
      WAIT_DONE: if (!tx_busy) state_nx = GAP;
      GAP:       if (gap_cnt == '0) state_nx = last ? IDLE : TRIGGER;
      default:   state_nx = IDLE;
    endcase
  end

  assign tx_start     = (state == TRIGGER);
  assign frame_active = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
      pending  <= '0;
      overrun  <= '0;
      tx_error <= 1'b0;
      ptr      <= '0;
      frm_data <= '0;
      frm_id   <= '0;
      byte_idx <= '0;
      abort    <= 1'b0;
      gap_cnt  <= '0;
      ack_cnt  <= '0;
      tx_data  <= '0;
    end else begin
      // A capture on the grant edge keeps the channel pending with the new sample.
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_valid[k]) begin
          hold[k]    <= ch_data[k*DATA_W +: DATA_W];
          pending[k] <= 1'b1;
        end else if (grant && int'(grant_idx) == k) begin
          pending[k] <= 1'b0;
        end
      end
      overrun <= (clear_flags ? '0 : overrun) | ovr_set;
      if (timeout)          tx_error <= 1'b1;
      else if (clear_flags) tx_error <= 1'b0;

      case (state)
        IDLE: if (grant) begin
          ptr      <= rr_next(grant_idx, 1);
          frm_data <= hold[grant_idx];
          frm_id   <= grant_id;
          byte_idx <= '0;
          abort    <= 1'b0;
          tx_data  <= grant_id;
          ack_cnt  <= AW'(ACK_TIMEOUT - 1);
        end
        TRIGGER: if (!tx_busy) begin
          if (ack_cnt == '0) begin
            abort   <= 1'b1;
            gap_cnt <= GW'(GAP_CYCLES - 1);
          end else begin
            ack_cnt <= ack_cnt - AW'(1);
          end
        end
        WAIT_DONE: if (!tx_busy) gap_cnt <= GW'(GAP_CYCLES - 1);
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (!last) begin
            byte_idx <= nxt_idx;
            tx_data  <= next_byte;
            ack_cnt  <= AW'(ACK_TIMEOUT - 1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_channel_uart_framer.sv
// Scoreboard bench: stimulus queues expected bytes, a UART model pops and checks
// each byte plus inter-byte and post-terminator gap lengths.
`timescale 1ns/1ps
module tb_multi_channel_uart_framer;
  localparam int GAP  = 200;
  localparam int ACK  = 1024;
  localparam int BUSY = 5;

  logic        clk;
  logic        reset;
  logic [3:0]  ch_valid;
  logic [63:0] ch_data;
  logic        clear_flags;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        frame_active;
  logic [3:0]  overrun;
  logic        tx_error;

  int          checks;
  int          errors;
  logic [9:0]  exp_q[$];   // {first, last, byte}
  bit          uart_en;
  int          busy_left;
  int          since;
  bit          chk_fall;

  multi_channel_uart_framer #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .clear_flags(clear_flags), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .frame_active(frame_active), .overrun(overrun),
    .tx_error(tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input int ch, input logic [15:0] d);
    logic [7:0] id;
    id = 8'hA0 + 8'(ch);
    exp_q.push_back({2'b10, id});
    exp_q.push_back({2'b00, d[15:8]});
    exp_q.push_back({2'b00, d[7:0]});
    exp_q.push_back({2'b00, id ^ d[15:8] ^ d[7:0]});
    exp_q.push_back({2'b01, 8'h0A});
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [63:0] data);
    @(negedge clk);
    ch_valid = mask;
    ch_data  = data;
    @(negedge clk);
    ch_valid = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || frame_active || tx_busy) && n < 20000);
    check(name, 32'(n < 20000), 32'd1);
  endtask

  // UART model + monitor
  initial begin
    logic [9:0] e;
    tx_busy   = 1'b0;
    busy_left = 0;
    since     = 0;
    chk_fall  = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy = 1'b0;
          since   = 0;
        end
      end else begin
        since++;
        if (chk_fall && !frame_active) begin
          check("term_gap", 32'(since), 32'(GAP + 1));
          chk_fall = 1'b0;
        end
        if (uart_en && tx_start) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("byte", 32'(tx_data), 32'(e[7:0]));
            if (!e[9]) check("byte_gap", 32'(since), 32'(GAP + 1));
            chk_fall = e[8];
          end
          tx_busy   = 1'b1;
          busy_left = BUSY;
        end
      end
    end
  end

  initial begin
    int n, hi, starts;
    checks = 0; errors = 0;
    reset = 1'b0; ch_valid = '0; ch_data = '0; clear_flags = 1'b0; uart_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_frame_active", 32'(frame_active), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_tx_error", 32'(tx_error), 0);
    reset = 1'b1;

    // Round-robin from pointer 0
    push_frame(0, 16'hBEEF); push_frame(2, 16'h0102); push_frame(3, 16'hFFFF);
    strobe(4'b1101, {16'hFFFF, 16'h0102, 16'h0000, 16'hBEEF});
    wait_idle("rr_first_done");
    push_frame(0, 16'h1111); push_frame(3, 16'h3333);
    strobe(4'b1001, {16'h3333, 16'h0000, 16'h0000, 16'h1111});
    wait_idle("rr_second_done");
    check("rr_overrun", 32'(overrun), 0);

    // Single ch1 frame (hand values) and a ch2 overrun queued behind it
    exp_q.push_back({2'b10, 8'hA1}); exp_q.push_back({2'b00, 8'h12});
    exp_q.push_back({2'b00, 8'h34}); exp_q.push_back({2'b00, 8'h87});
    exp_q.push_back({2'b01, 8'h0A});
    push_frame(2, 16'h0002);
    strobe(4'b0010, {16'h0, 16'h0, 16'h1234, 16'h0});
    repeat (20) @(negedge clk);
    strobe(4'b0100, {16'h0, 16'h0001, 16'h0, 16'h0});
    strobe(4'b0100, {16'h0, 16'h0002, 16'h0, 16'h0});
    wait_idle("single_overrun_done");
    check("overrun_set", 32'(overrun), 32'h4);
    check("no_tx_error", 32'(tx_error), 0);
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    check("overrun_cleared", 32'(overrun), 0);

    // New ch0 capture on its own grant edge
    push_frame(0, 16'hAAAA); push_frame(0, 16'h5555);
    @(negedge clk); ch_valid = 4'b0001; ch_data = {48'h0, 16'hAAAA};
    @(negedge clk); ch_data = {48'h0, 16'h5555};
    @(negedge clk); ch_valid = '0;
    wait_idle("collision_done");
    check("collision_overrun", 32'(overrun), 0);

    // Ack timeout: UART never answers
    uart_en = 1'b0;
    strobe(4'b1000, {16'h7777, 48'h0});
    n = 0;
    while (!tx_start && n < 50) begin @(negedge clk); n++; end
    check("timeout_start_seen", 32'(tx_start), 1);
    hi = 0;
    while (tx_start && hi < 5000) begin hi++; @(negedge clk); end
    check("ack_timeout_len", 32'(hi), 32'(ACK));
    check("tx_error_set", 32'(tx_error), 1);
    starts = 0; n = 0;
    while (frame_active && n < 5000) begin
      @(negedge clk);
      if (tx_start) starts++;
      n++;
    end
    check("no_more_bytes", 32'(starts), 0);
    check("timeout_to_idle", 32'(frame_active), 0);
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    check("tx_error_cleared", 32'(tx_error), 0);
    uart_en = 1'b1;

    // Reset while data byte 2 is on the wire
    push_frame(1, 16'h1234);
    strobe(4'b0010, {16'h0, 16'h0, 16'h1234, 16'h0});
    n = 0;
    while (exp_q.size() > 2 && n < 5000) begin @(negedge clk); n++; end
    check("reached_data_byte2", 32'(exp_q.size()), 2);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_frame_active", 32'(frame_active), 0);
    exp_q.delete();
    busy_left = 0; tx_busy = 1'b0; chk_fall = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push_frame(1, 16'hC3C3);
    strobe(4'b0010, {16'h0, 16'h0, 16'hC3C3, 16'h0});
    wait_idle("after_reset_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
